vga_timing_output: RTL
======================

VGA_TIMING_OUTPUT -- requirements
Module: vga_timing_output

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_VISIBLE, default 480, visible lines per frame.
REQ-004 SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameter COLOR_BITS, default 4, bits per colour channel.
REQ-006 SHALL have parameter PIXEL_LATENCY, default 2, cycles from row/column to valid pixel_* inputs (range 0..8).
REQ-007 SHALL have parameter SYNC_ACTIVE, default 0, logic level of hsync/vsync while in the sync pulse.
REQ-008 vga_clock  input  1  pixel clock; the block's only clock.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 enable  input  1  1 = timing runs; 0 = counters hold, output blanked.
REQ-011 mode  input  2  0 pass-through, 1 colour bars, 2 solid, 3 black.
REQ-012 solid_color  input  3*COLOR_BITS  {r,g,b} used in mode 2.
REQ-013 pixel_red/pixel_green/pixel_blue  input  COLOR_BITS each  drawer colour for the coordinate issued PIXEL_LATENCY cycles earlier.
REQ-014 row, column  output  32 (int)  current undelayed v/h counter, fed to the drawer.
REQ-015 frame_start  output  1  one-cycle pulse when row=0 and column=0.
REQ-016 hsync, vsync  output  1  sync outputs, aligned with colour outputs.
REQ-017 display_enable  output  1  visible-area flag, aligned with colour outputs.
REQ-018 vga_red/vga_green/vga_blue  output  COLOR_BITS each  registered colour to the DAC.

Function
REQ-019 column SHALL count 0..H_TOTAL-1 (H_TOTAL=sum of H params), wrapping to 0 and incrementing row; row SHALL wrap from V_TOTAL-1 to 0.
REQ-020 Raw visible = column<H_VISIBLE and row<V_VISIBLE; raw hsync active for column in [H_VISIBLE+H_FRONT, +H_SYNC); raw vsync likewise on row.
REQ-021 Raw visible, hsync, vsync and column SHALL pass through a PIXEL_LATENCY-stage delay line; the output register SHALL add one cycle, so total latency from counter to hsync/vsync/display_enable/colour is PIXEL_LATENCY+1.
REQ-022 mode and solid_color SHALL be latched only on the cycle frame_start is high; changes mid-frame take effect next frame.
REQ-023 Delayed visible=0 SHALL force colour outputs to 0 in every mode.
REQ-024 Mode 1: eight equal bars of width H_VISIBLE/8 from delayed column; bar k colour = {k[2],k[1],k[0]} each bit replicated to COLOR_BITS (bar 0 black, bar 7 white); columns >= 8*(H_VISIBLE/8) black.
REQ-025 enable=0: counters and delay line hold; colour outputs 0, hsync/vsync at inactive level (~SYNC_ACTIVE), display_enable 0, frame_start 0; on re-enable timing resumes from the held count.
REQ-026 frame_start SHALL be combinational from the counters gated by enable.
REQ-027 PIXEL_LATENCY=0 SHALL remove the delay line, leaving only the output register.

Reset
REQ-028 Asserted reset, including mid-frame, SHALL immediately set row=column=0, clear all delay stages, colour outputs 0, display_enable 0, hsync/vsync ~SYNC_ACTIVE, latched mode 3 (black).
REQ-029 After reset release, the first frame_start SHALL occur on the first enabled cycle and load mode.

Structure
REQ-030 Default timing constants, mode encodings and a colour-triplet typedef SHALL live in the shared VGA package.
REQ-031 The delay line SHALL be one sub-module, vga_delay_line, parametrised by width and depth.

Verification
REQ-032 Defaults, mode 0: hsync low exactly 96 cycles, period 800; vsync low 2 lines, period 525 lines (420000 cycles).
REQ-033 Drive pixel_red = column[3:0] delayed by 2 in the bench: output red at first display_enable cycle of each line = 0, next cycle = 1.
REQ-034 Switch mode 0->1 at row 100: current frame stays pass-through; next frame bar 3 (columns 240..319) = {0,F,F}.
REQ-035 Drop enable for 50 cycles at column 300: counters hold at 300, outputs black and syncs high; resumes at column 301 after re-enable.
REQ-036 Assert reset at row 200, column 500: all outputs reset same cycle; after release, frame_start on first cycle and row/column = 0.
REQ-037 PIXEL_LATENCY=0 build: display_enable first high exactly 1 cycle after column=0, row=0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing constants, output
// mode encodings and the default-width colour triplet type.
package vga_pkg;

    localparam int DEF_H_VISIBLE  = 640;
    localparam int DEF_H_FRONT    = 16;
    localparam int DEF_H_SYNC     = 96;
    localparam int DEF_H_BACK     = 48;
    localparam int DEF_V_VISIBLE  = 480;
    localparam int DEF_V_FRONT    = 10;
    localparam int DEF_V_SYNC     = 2;
    localparam int DEF_V_BACK     = 33;
    localparam int DEF_COLOR_BITS = 4;
    localparam int DEF_PIXEL_LAT  = 2;

    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,   // drawer colour passed through
        MODE_BARS  = 2'd1,   // eight vertical colour bars
        MODE_SOLID = 2'd2,   // latched solid colour
        MODE_BLACK = 2'd3    // all black
    } vga_mode_e;

    // Colour triplet at the default channel width.
    typedef struct packed {
        logic [DEF_COLOR_BITS-1:0] r;
        logic [DEF_COLOR_BITS-1:0] g;
        logic [DEF_COLOR_BITS-1:0] b;
    } vga_rgb_t;

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register used to align per-pixel timing flags with the
// drawer's pixel latency.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears every stage
//   en_i   : shift enable; stages hold while low
//   d_i    : data in
//   q_o    : data out, DEPTH enabled cycles later (combinational when DEPTH=0)
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q_o = d_i;
        end else begin : g_pipe
            logic [DEPTH-1:0][WIDTH-1:0] stage_q;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    stage_q <= '0;
                end else if (en_i) begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_output.sv
// VGA timing generator and output stage. Free-running h/v counters are
// handed to an external drawer; timing flags are delayed to meet the
// drawer's colour PIXEL_LATENCY cycles later, then a single output register
// drives sync, display_enable and colour to the DAC.
//   vga_clock      : pixel clock
//   reset          : asynchronous active-high reset
//   enable         : run timing; low holds counters and blanks outputs
//   mode           : 0 pass-through, 1 colour bars, 2 solid, 3 black
//   solid_color    : {r,g,b} for mode 2
//   pixel_*        : drawer colour for the coordinate issued PIXEL_LATENCY ago
//   row, column    : current undelayed counters
//   frame_start    : high while row=column=0 and enabled
//   hsync, vsync   : registered syncs, SYNC_ACTIVE while in the pulse
//   display_enable : registered visible-area flag
//   vga_*          : registered colour
module vga_timing_output
    import vga_pkg::*;
#(
    parameter int H_VISIBLE     = DEF_H_VISIBLE,
    parameter int H_FRONT       = DEF_H_FRONT,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BACK        = DEF_H_BACK,
    parameter int V_VISIBLE     = DEF_V_VISIBLE,
    parameter int V_FRONT       = DEF_V_FRONT,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BACK        = DEF_V_BACK,
    parameter int COLOR_BITS    = DEF_COLOR_BITS,
    parameter int PIXEL_LATENCY = DEF_PIXEL_LAT,
    parameter bit SYNC_ACTIVE   = 1'b0
) (
    input  logic                    vga_clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [1:0]              mode,
    input  logic [3*COLOR_BITS-1:0] solid_color,
    input  logic [COLOR_BITS-1:0]   pixel_red,
    input  logic [COLOR_BITS-1:0]   pixel_green,
    input  logic [COLOR_BITS-1:0]   pixel_blue,
    output logic [31:0]             row,
    output logic [31:0]             column,
    output logic                    frame_start,
    output logic                    hsync,
    output logic                    vsync,
    output logic                    display_enable,
    output logic [COLOR_BITS-1:0]   vga_red,
    output logic [COLOR_BITS-1:0]   vga_green,
    output logic [COLOR_BITS-1:0]   vga_blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int CW      = $clog2(H_TOTAL);   // delayed column only needs to cover a line
    localparam int BAR_W   = H_VISIBLE / 8;
    localparam int DW      = CW + 3;

    typedef struct packed {
        logic [COLOR_BITS-1:0] r;
        logic [COLOR_BITS-1:0] g;
        logic [COLOR_BITS-1:0] b;
    } rgb_t;

    // ---------------- counters ----------------
    logic [31:0] h_q, h_d, v_q, v_d;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (enable) begin
            if (h_q == 32'(H_TOTAL - 1)) begin
                h_d = '0;
                v_d = (v_q == 32'(V_TOTAL - 1)) ? '0 : v_q + 32'd1;
            end else begin
                h_d = h_q + 32'd1;
            end
        end
    end

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign row         = v_q;
    assign column      = h_q;
    assign frame_start = enable && (h_q == '0) && (v_q == '0);

    // ---------------- raw timing flags ----------------
    logic vis_raw, hs_raw, vs_raw;

    assign vis_raw = (h_q < 32'(H_VISIBLE)) && (v_q < 32'(V_VISIBLE));
    assign hs_raw  = (h_q >= 32'(H_VISIBLE + H_FRONT)) &&
                     (h_q <  32'(H_VISIBLE + H_FRONT + H_SYNC));
    assign vs_raw  = (v_q >= 32'(V_VISIBLE + V_FRONT)) &&
                     (v_q <  32'(V_VISIBLE + V_FRONT + V_SYNC));

    // ---------------- drawer-latency alignment ----------------
    logic [DW-1:0] dl_in, dl_out;
    logic          dl_vis, dl_hs, dl_vs;
    logic [CW-1:0] dl_col;

    assign dl_in = {vis_raw, hs_raw, vs_raw, h_q[CW-1:0]};

    vga_delay_line #(
        .WIDTH (DW),
        .DEPTH (PIXEL_LATENCY)
    ) u_delay (
        .clk_i (vga_clock),
        .rst_i (reset),
        .en_i  (enable),
        .d_i   (dl_in),
        .q_o   (dl_out)
    );

    assign {dl_vis, dl_hs, dl_vs, dl_col} = dl_out;

    // ---------------- per-frame mode latch ----------------
    // Sampled only at frame_start so a frame is never drawn in two modes.
    vga_mode_e mode_q;
    rgb_t      solid_q;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            mode_q  <= MODE_BLACK;
            solid_q <= '0;
        end else if (frame_start) begin
            mode_q  <= vga_mode_e'(mode);
            solid_q <= rgb_t'(solid_color);
        end
    end

    // ---------------- colour select ----------------
    rgb_t          pix_d;
    logic [CW-1:0] bar_idx;

    assign bar_idx = dl_col / CW'(BAR_W);

    always_comb begin
        pix_d = '0;
        if (dl_vis) begin
            unique case (mode_q)
                MODE_PASS: begin
                    pix_d.r = pixel_red;
                    pix_d.g = pixel_green;
                    pix_d.b = pixel_blue;
                end
                MODE_BARS: begin
                    // Leftover columns past the eighth bar stay black.
                    if (dl_col < CW'(8 * BAR_W)) begin
                        pix_d.r = {COLOR_BITS{bar_idx[2]}};
                        pix_d.g = {COLOR_BITS{bar_idx[1]}};
                        pix_d.b = {COLOR_BITS{bar_idx[0]}};
                    end
                end
                MODE_SOLID: pix_d = solid_q;
                default:    pix_d = '0;
            endcase
        end
    end

    // ---------------- output register ----------------
    rgb_t rgb_q;
    logic de_q, hs_q, vs_q;

    always_ff @(posedge vga_clock or posedge reset) begin
        if (reset) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~SYNC_ACTIVE;
            vs_q  <= ~SYNC_ACTIVE;
        end else if (!enable) begin
            rgb_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~SYNC_ACTIVE;
            vs_q  <= ~SYNC_ACTIVE;
        end else begin
            rgb_q <= pix_d;
            de_q  <= dl_vis;
            hs_q  <= dl_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vs_q  <= dl_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

    assign vga_red        = rgb_q.r;
    assign vga_green      = rgb_q.g;
    assign vga_blue       = rgb_q.b;
    assign display_enable = de_q;
    assign hsync          = hs_q;
    assign vsync          = vs_q;

endmodule
